rs232_rx: RTL and testbench



---
 rtl/rs232_pkg.sv | 13 +
 rtl/rs232_sync.sv | 26 ++
 rtl/rs232_rx.sv | 128 ++++++++++++
 tb/tb_rs232_rx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rs232_pkg.sv
// Shared constants for the RS232 link: bit timing, data width and receiver state codes.
package rs232_pkg;

  localparam int CLK_PER_BIT_9600 = 5208;
  localparam int DATA_W           = 8;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

endpackage

// File: rtl/rs232_sync.sv
// Multi-flop synchroniser for asynchronous inputs; resets to all-ones so an idle-high line
// does not produce a spurious edge when reset is released.
module rs232_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_reg [STAGES];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < STAGES; i++) stage_reg[i] <= '1;
    end else begin
      stage_reg[0] <= d;
      for (int i = 1; i < STAGES; i++) stage_reg[i] <= stage_reg[i-1];
    end
  end

  assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/rs232_rx.sv
// 8N1 UART receiver: validates the start bit at half a bit, then samples data and stop bits
// once per bit period, LSB first.
module rs232_rx
  import rs232_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_9600,
  parameter int HALF_BIT    = CLK_PER_BIT / 2,
  parameter int CNT_W       = 13
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              rx,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(DATA_W - 1);

  logic              rx_s;
  logic              rx_s_d_reg;
  logic              fall;
  logic [2:0]        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [2:0]        bit_idx_reg, bit_idx_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic              data_valid_reg, data_valid_next;
  logic              frame_err_reg, frame_err_next;

  rs232_sync #(.WIDTH(1), .STAGES(2)) u_sync (
    .clk   (clk),
    .n_rst (n_rst),
    .d     (rx),
    .q     (rx_s)
  );

  assign fall = rx_s_d_reg & ~rx_s;

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    bit_idx_next    = bit_idx_reg;
    shift_next      = shift_reg;
    data_next       = data_reg;
    data_valid_next = 1'b0;
    frame_err_next  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (fall) begin
          state_next = S_START;
          cnt_next   = '0;
        end
      end
      S_START: begin
        if (cnt_reg == HALF_LAST) begin
          // A start bit that is already high again at mid-bit was only a glitch.
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          shift_next = {rx_s, shift_reg[DATA_W-1:1]};
          if (bit_idx_reg == IDX_LAST) state_next = S_STOP;
          else bit_idx_next = bit_idx_reg + 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            data_next       = shift_reg;
            data_valid_next = 1'b1;
            state_next      = S_IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = S_WAIT_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        // Held-low line (break or fault): wait for idle before looking for a new start edge.
        if (rx_s) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_s_d_reg     <= 1'b1;
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      data_reg       <= '0;
      data_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      rx_s_d_reg     <= rx_s;
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      bit_idx_reg    <= bit_idx_next;
      shift_reg      <= shift_next;
      data_reg       <= data_next;
      data_valid_reg <= data_valid_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  assign data       = data_reg;
  assign data_valid = data_valid_reg;
  assign frame_err  = frame_err_reg;
  assign busy       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_rs232_rx.sv
// Directed bench for rs232_rx at 16 clocks/bit: table of single frames plus hand-written
// latency, back-to-back, glitch, mid-frame reset and loopback sequences.
module tb_rs232_rx;

  localparam int CPB = 16;

  logic       clk   = 1'b0;
  logic       n_rst = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  rs232_rx #(.CLK_PER_BIT(CPB), .CNT_W(5)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .rx         (rx),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] tx_byte;
    logic       stop_bit;
    int         hold_low;
    logic [7:0] exp_data;
    int         exp_valid;
    int         exp_ferr;
  } vec_t;

  vec_t vecs [7];

  int         cyc            = 0;
  int         valid_cnt      = 0;
  int         ferr_cnt       = 0;
  int         both_cnt       = 0;
  int         last_valid_cyc = 0;
  int         prev_valid_cyc = 0;
  logic [7:0] rx_q [$];
  logic [7:0] sent_q [$];
  int         n_checks = 0;
  int         n_fail   = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Pulse monitor: every one-cycle strobe is seen at exactly one falling edge.
  initial forever begin
    @(negedge clk);
    if (data_valid) begin
      valid_cnt++;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      rx_q.push_back(data);
    end
    if (frame_err) ferr_cnt++;
    if (data_valid && frame_err) both_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // All line drivers start and end on a falling clock edge.
  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int v0, f0, t0, base, busy_cyc;
    logic busy_dropped;
    logic [7:0] b;

    vecs[0] = '{8'hA5, 1'b1,  0, 8'hA5, 1, 0};
    vecs[1] = '{8'h3C, 1'b0, 40, 8'hA5, 0, 1};
    vecs[2] = '{8'h55, 1'b1,  0, 8'h55, 1, 0};
    vecs[3] = '{8'h00, 1'b1,  0, 8'h00, 1, 0};
    vecs[4] = '{8'hFF, 1'b1,  0, 8'hFF, 1, 0};
    vecs[5] = '{8'h3C, 1'b0,  0, 8'hFF, 0, 1};
    vecs[6] = '{8'h7E, 1'b1,  0, 8'h7E, 1, 0};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset data", int'(data), 0);
    check("reset data_valid", int'(data_valid), 0);
    check("reset frame_err", int'(frame_err), 0);
    check("reset busy", int'(busy), 0);
    n_rst = 1'b1;
    idle(5);

    // Single frame with latency measured from the start edge
    v0 = valid_cnt; f0 = ferr_cnt; t0 = cyc;
    send_frame(8'hA5, 1'b1);
    idle(20);
    check("A5 valid pulses", valid_cnt - v0, 1);
    check("A5 frame_err pulses", ferr_cnt - f0, 0);
    check("A5 data", int'(data), 8'hA5);
    check_range("A5 latency", last_valid_cyc - t0, 153, 155);
    $display("single frame A5: data %02h latency %0d", data, last_valid_cyc - t0);

    // Back-to-back frames, no idle between stop and next start
    v0 = valid_cnt; base = rx_q.size();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(20);
    check("b2b valid pulses", valid_cnt - v0, 2);
    check("b2b spacing", last_valid_cyc - prev_valid_cyc, 160);
    if (rx_q.size() >= base + 2) begin
      check("b2b first byte", int'(rx_q[base]), 8'h00);
      check("b2b second byte", int'(rx_q[base+1]), 8'hFF);
    end
    $display("back-to-back 00,FF: %0d bytes, spacing %0d", valid_cnt - v0, last_valid_cyc - prev_valid_cyc);

    // Start-bit glitch
    v0 = valid_cnt; f0 = ferr_cnt; busy_cyc = 0;
    rx = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 4) rx = 1'b1;
      @(negedge clk);
      if (busy) busy_cyc++;
    end
    check_range("glitch busy cycles", busy_cyc, 1, 9);
    check("glitch valid pulses", valid_cnt - v0, 0);
    check("glitch frame_err pulses", ferr_cnt - f0, 0);
    check("glitch busy after", int'(busy), 0);
    $display("glitch: busy for %0d cycles", busy_cyc);

    // Table of single frames
    for (int k = 0; k < 7; k++) begin
      v0 = valid_cnt; f0 = ferr_cnt; busy_dropped = 1'b0;
      send_frame(vecs[k].tx_byte, vecs[k].stop_bit);
      for (int i = 0; i < vecs[k].hold_low; i++) begin
        @(negedge clk);
        if (!busy) busy_dropped = 1'b1;
      end
      if (vecs[k].hold_low > 0) check($sformatf("vec%0d busy while held low", k), int'(busy_dropped), 0);
      idle(20);
      check($sformatf("vec%0d valid pulses", k), valid_cnt - v0, vecs[k].exp_valid);
      check($sformatf("vec%0d frame_err pulses", k), ferr_cnt - f0, vecs[k].exp_ferr);
      check($sformatf("vec%0d data", k), int'(data), int'(vecs[k].exp_data));
      check($sformatf("vec%0d busy idle", k), int'(busy), 0);
      $display("vec %0d: byte %02h stop %0b -> data %02h valid %0d ferr %0d", k,
               vecs[k].tx_byte, vecs[k].stop_bit, data, valid_cnt - v0, ferr_cnt - f0);
    end

    // Reset during bit 3 of 8'hC3
    v0 = valid_cnt; f0 = ferr_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("rst busy", int'(busy), 0);
    check("rst data", int'(data), 0);
    check("rst data_valid", int'(data_valid), 0);
    check("rst frame_err", int'(frame_err), 0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    n_rst = 1'b1;
    idle(10);
    check("rst no valid", valid_cnt - v0, 0);
    check("rst no frame_err", ferr_cnt - f0, 0);
    send_frame(8'h81, 1'b1);
    idle(20);
    check("post-rst data", int'(data), 8'h81);
    check("post-rst valid pulses", valid_cnt - v0, 1);
    $display("mid-frame reset then 81: data %02h", data);

    // Loopback: transmitter model drives random bytes with 0..2 idle clocks between frames
    v0 = valid_cnt; f0 = ferr_cnt; base = rx_q.size();
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom_range(0, 255));
      sent_q.push_back(b);
      send_frame(b, 1'b1);
      idle($urandom_range(0, 2));
    end
    idle(20);
    check("loopback count", valid_cnt - v0, 256);
    check("loopback frame_err", ferr_cnt - f0, 0);
    for (int i = 0; i < 256; i++) begin
      if (base + i < rx_q.size()) begin
        check($sformatf("loopback byte %0d", i), int'(rx_q[base+i]), int'(sent_q[i]));
        $display("loopback %0d: sent %02h got %02h", i, sent_q[i], rx_q[base+i]);
      end
    end

    check("valid and frame_err together", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
